// File: rtl/quad_enc_counter.sv
// -----------------------------------------------------------------------------
// quad_enc_counter
//   Quadrature encoder front end for one wheel. The raw A/B pins are
//   synchronised (two flops each), glitch-filtered (FILT_LEN identical samples
//   required) and decoded at 4x resolution into a wrapping signed position
//   count plus a direction flag for the motor controller.
//
// Ports
//   i_Clock  : system clock
//   i_Rst    : synchronous active-high reset
//   i_EncA   : raw encoder channel A (asynchronous)
//   i_EncB   : raw encoder channel B (asynchronous)
//   i_Zero   : synchronous clear of count and error flag
//   o_EncCnt : two's-complement position count, wraps modulo 2^CNT_W
//   o_WhlDir : direction of last valid step, 1 = forward
//   o_Step   : one-cycle pulse on every valid count update
//   o_Err    : sticky flag, set on a two-bit (illegal) transition
// -----------------------------------------------------------------------------
module quad_enc_counter #(
  parameter int CNT_W    = 24,
  parameter int FILT_LEN = 3,
  parameter bit INVERT   = 1'b0
) (
  input  logic             i_Clock,
  input  logic             i_Rst,
  input  logic             i_EncA,
  input  logic             i_EncB,
  input  logic             i_Zero,
  output logic [CNT_W-1:0] o_EncCnt,
  output logic             o_WhlDir,
  output logic             o_Step,
  output logic             o_Err
);

  localparam logic [3:0]       FILT_MAX = 4'(FILT_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // Maps the Gray-coded {A,B} state onto its position in the forward cycle
  // 00 -> 10 -> 11 -> 01, so a forward step is a +1 (mod 4) position change.
  function automatic logic [1:0] phase_pos(input logic [1:0] ab);
    phase_pos = {ab[0], ab[1] ^ ab[0]};
  endfunction

  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] cand;
  logic [3:0] run;
  logic [1:0] qs;
  logic [1:0] qs_prev;
  logic       init;
  logic       qs_upd;

  logic [3:0] run_next;
  logic       qualify;
  logic [1:0] delta;
  logic       is_fwd;
  logic       is_rev;
  logic       is_bad;
  logic       cnt_up;
  logic       cnt_dn;

  // Filter run length and qualification of a new filtered state
  always_comb begin
    run_next = 4'd1;
    if (sync2 == cand) begin
      // Saturate so long stable periods never wrap the counter.
      if (run >= FILT_MAX) begin
        run_next = FILT_MAX;
      end else begin
        run_next = run + 4'd1;
      end
    end else begin
      run_next = 4'd1;
    end
    // While initialising, any qualified value loads Qs, even one equal to it.
    qualify = (run_next >= FILT_MAX) && (init || (sync2 != qs));
  end

  // Classify the Qs change registered in the previous cycle
  always_comb begin
    delta  = phase_pos(qs) - phase_pos(qs_prev);
    is_fwd = qs_upd && (delta == 2'd1);
    is_rev = qs_upd && (delta == 2'd3);
    is_bad = qs_upd && (delta == 2'd2);
    if (INVERT) begin
      cnt_up = is_rev;
      cnt_dn = is_fwd;
    end else begin
      cnt_up = is_fwd;
      cnt_dn = is_rev;
    end
  end

  // Synchroniser, filter state and registered decode outputs
  always_ff @(posedge i_Clock) begin
    if (i_Rst) begin
      sync1    <= 2'b00;
      sync2    <= 2'b00;
      cand     <= 2'b00;
      run      <= 4'd0;
      qs       <= 2'b00;
      qs_prev  <= 2'b00;
      init     <= 1'b1;
      qs_upd   <= 1'b0;
      o_EncCnt <= '0;
      o_WhlDir <= 1'b1;
      o_Step   <= 1'b0;
      o_Err    <= 1'b0;
    end else begin
      sync1 <= {i_EncA, i_EncB};
      sync2 <= sync1;
      cand  <= sync2;
      run   <= run_next;

      // The initialising load is flagged as "no update" so it never counts.
      if (qualify) begin
        qs      <= sync2;
        qs_prev <= qs;
        init    <= 1'b0;
        qs_upd  <= ~init;
      end else begin
        qs_upd  <= 1'b0;
      end

      o_Step <= is_fwd | is_rev;

      if (is_fwd | is_rev) begin
        o_WhlDir <= cnt_up;
      end else begin
        o_WhlDir <= o_WhlDir;
      end

      // A coincident zero discards the step but the pulse and direction stand.
      if (i_Zero) begin
        o_EncCnt <= '0;
      end else if (cnt_up) begin
        o_EncCnt <= o_EncCnt + CNT_ONE;
      end else if (cnt_dn) begin
        o_EncCnt <= o_EncCnt - CNT_ONE;
      end else begin
        o_EncCnt <= o_EncCnt;
      end

      if (i_Zero) begin
        o_Err <= 1'b0;
      end else if (is_bad) begin
        o_Err <= 1'b1;
      end else begin
        o_Err <= o_Err;
      end
    end
  end

endmodule

// File: tb/tb_quad_enc_counter.sv
// -----------------------------------------------------------------------------
// tb_quad_enc_counter
//   Bench for quad_enc_counter. Two instances share the pin stimulus: one with
//   INVERT=0 and one with INVERT=1. A behavioural model derives the expected
//   outputs of both from the pin history, and a compare process checks every
//   cycle; directed sequences add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_quad_enc_counter;

  localparam int FILT = 3;

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic        zero = 1'b0;
  logic [1:0]  pins = 2'b00;

  logic [23:0] cnt0, cnt1;
  logic        dir0, dir1, step0, step1, err0, err1;

  int checks = 0;
  int errors = 0;
  int cur    = 0;
  int ns     = 0;
  int ns2    = 0;

  logic [1:0] seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  always #5 clk = ~clk;

  quad_enc_counter #(.CNT_W(24), .FILT_LEN(FILT), .INVERT(1'b0)) u_dut (
    .i_Clock(clk), .i_Rst(rst), .i_EncA(pins[1]), .i_EncB(pins[0]),
    .i_Zero(zero), .o_EncCnt(cnt0), .o_WhlDir(dir0), .o_Step(step0),
    .o_Err(err0)
  );

  quad_enc_counter #(.CNT_W(24), .FILT_LEN(FILT), .INVERT(1'b1)) u_inv (
    .i_Clock(clk), .i_Rst(rst), .i_EncA(pins[1]), .i_EncB(pins[0]),
    .i_Zero(zero), .o_EncCnt(cnt1), .o_WhlDir(dir1), .o_Step(step1),
    .o_Err(err1)
  );

  // ---------------- behavioural model ----------------
  logic [1:0]  m_s1, m_s2, m_s, m_last, m_qs, m_old, m_new;
  bit          m_have, m_known, m_pend, m_ok;
  int          m_run;
  logic [23:0] m_cnt [2];
  bit          m_dir [2];
  bit          m_step[2];
  bit          m_err [2];

  function automatic int seq_idx(input logic [1:0] ab);
    for (int i = 0; i < 4; i++) begin
      if (seq[i] == ab) return i;
    end
    return 0;
  endfunction

  initial begin : model
    int  d;
    bit  up;
    m_ok = 1'b0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_s1 = 2'b00; m_s2 = 2'b00; m_have = 1'b0; m_run = 0;
        m_known = 1'b0; m_pend = 1'b0; m_qs = 2'b00;
        for (int k = 0; k < 2; k++) begin
          m_cnt[k] = 24'd0; m_dir[k] = 1'b1; m_step[k] = 1'b0; m_err[k] = 1'b0;
        end
        m_ok = 1'b1;
      end else begin
        // value the filter sees this edge is the pin value from two edges ago
        m_s  = m_s2;
        m_s2 = m_s1;
        m_s1 = pins;
        for (int k = 0; k < 2; k++) begin
          m_step[k] = 1'b0;
          if (m_pend) begin
            d = (seq_idx(m_new) - seq_idx(m_old) + 4) % 4;
            if (d == 1 || d == 3) begin
              up = (d == 1) ^ (k == 1);
              m_step[k] = 1'b1;
              m_dir[k]  = up;
              m_cnt[k]  = up ? m_cnt[k] + 24'd1 : m_cnt[k] - 24'd1;
            end else if (d == 2) begin
              m_err[k] = 1'b1;
            end
          end
          if (zero) begin
            m_cnt[k] = 24'd0;
            m_err[k] = 1'b0;
          end
        end
        m_pend = 1'b0;
        m_run  = (m_have && m_s == m_last) ? m_run + 1 : 1;
        m_last = m_s;
        m_have = 1'b1;
        if (m_run >= FILT && (!m_known || m_s != m_qs)) begin
          if (m_known) begin
            m_pend = 1'b1; m_old = m_qs; m_new = m_s;
          end
          m_qs = m_s;
          m_known = 1'b1;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin : compare
    forever begin
      @(negedge clk);
      if (m_ok) begin
        checks++;
        if ({cnt0, dir0, step0, err0} !== {m_cnt[0], m_dir[0], m_step[0], m_err[0]}) begin
          errors++;
          $display("FAIL model_cmp inst0 t=%0t got cnt=%h dir=%b step=%b err=%b exp cnt=%h dir=%b step=%b err=%b",
                   $time, cnt0, dir0, step0, err0, m_cnt[0], m_dir[0], m_step[0], m_err[0]);
        end
        checks++;
        if ({cnt1, dir1, step1, err1} !== {m_cnt[1], m_dir[1], m_step[1], m_err[1]}) begin
          errors++;
          $display("FAIL model_cmp inst1 t=%0t got cnt=%h dir=%b step=%b err=%b exp cnt=%h dir=%b step=%b err=%b",
                   $time, cnt1, dir1, step1, err1, m_cnt[1], m_dir[1], m_step[1], m_err[1]);
        end
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge; drives pins and holds them n cycles, counting steps.
  task automatic phase(input logic [1:0] ab, input int n, input int lat, output int nsteps);
    int first;
    pins   = ab;
    nsteps = 0;
    first  = 0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (step0) begin
        nsteps++;
        if (first == 0) first = k;
      end
    end
    if (lat != 0) check("step_latency", first, lat);
  endtask

  task automatic fwd(input int n);
    int s;
    for (int i = 0; i < n; i++) begin
      cur = (cur + 1) % 4;
      phase(seq[cur], 10, FILT + 3, s);
      check("fwd_one_step", s, 1);
    end
  endtask

  task automatic rev(input int n);
    int s;
    for (int i = 0; i < n; i++) begin
      cur = (cur + 3) % 4;
      phase(seq[cur], 10, FILT + 3, s);
      check("rev_one_step", s, 1);
    end
  endtask

  task automatic pulse_zero();
    zero = 1'b1;
    @(negedge clk);
    zero = 1'b0;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin : stim
    int n;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cnt", cnt0, 0);
    check("rst_dir", dir0, 1);
    check("rst_step", step0, 0);
    check("rst_err", err0, 0);
    rst = 1'b0;

    // first qualified 00 only initialises
    phase(2'b00, 10, 0, ns);
    check("init_no_step", ns, 0);
    check("init_cnt", cnt0, 0);
    cur = 0;

    fwd(4);
    check("fwd4_cnt", cnt0, 32'h4);
    check("fwd4_dir", dir0, 1);
    check("inv_fwd4_cnt", cnt1, 32'hFFFFFC);
    check("inv_fwd4_dir", dir1, 0);

    pulse_zero();
    check("zero_cnt", cnt0, 0);
    rev(8);
    check("rev8_cnt", cnt0, 32'hFFFFF8);
    check("rev8_dir", dir0, 0);
    fwd(8);
    check("fwd8_cnt", cnt0, 0);
    check("inv_fwd8_cnt", cnt1, 0);

    // 2-cycle glitch is filtered, 3-cycle pulse counts up then down
    phase(2'b10, 2, 0, ns);
    phase(2'b00, 10, 0, ns2);
    check("glitch2_steps", ns + ns2, 0);
    check("glitch2_cnt", cnt0, 0);
    phase(2'b10, 3, 0, ns);
    phase(2'b00, 12, 0, ns2);
    check("pulse3_steps", ns + ns2, 2);
    check("pulse3_cnt", cnt0, 0);
    check("pulse3_dir", dir0, 0);

    // illegal 00 -> 11
    phase(2'b11, 10, 0, ns);
    cur = 2;
    check("illegal_steps", ns, 0);
    check("illegal_err", err0, 1);
    check("illegal_cnt", cnt0, 0);
    check("illegal_dir", dir0, 0);
    phase(2'b11, 5, 0, ns);
    check("illegal_sticky", err0, 1);
    pulse_zero();
    check("zero_err", err0, 0);
    check("zero_cnt2", cnt0, 0);

    // preload 5 then zero coincident with the decoded step
    fwd(5);
    check("preload_cnt", cnt0, 32'h5);
    cur  = (cur + 1) % 4;
    pins = seq[cur];
    repeat (5) @(negedge clk);
    zero = 1'b1;
    @(negedge clk);
    check("coinc_cnt", cnt0, 0);
    check("coinc_step", step0, 1);
    check("coinc_dir", dir0, 1);
    check("inv_coinc_step", step1, 1);
    check("inv_coinc_cnt", cnt1, 0);
    zero = 1'b0;
    repeat (4) @(negedge clk);

    // reset mid-sequence, next qualified state only initialises
    fwd(2);
    cur  = (cur + 1) % 4;
    pins = seq[cur];
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_cnt", cnt0, 0);
    check("midrst_dir", dir0, 1);
    check("midrst_step", step0, 0);
    check("midrst_err", err0, 0);
    check("inv_midrst_cnt", cnt1, 0);
    rst = 1'b0;
    phase(seq[cur], 10, 0, ns);
    check("midrst_init_steps", ns, 0);
    check("midrst_init_cnt", cnt0, 0);
    fwd(1);
    check("post_rst_cnt", cnt0, 32'h1);
    check("inv_post_rst_cnt", cnt1, 32'hFFFFFF);

    // random pins, hold lengths and occasional zero / reset
    for (int i = 0; i < 300; i++) begin
      pins = 2'($urandom_range(0, 3));
      n    = $urandom_range(1, 8);
      zero = ($urandom_range(0, 15) == 0);
      rst  = (i == 150);
      @(negedge clk);
      zero = 1'b0;
      rst  = 1'b0;
      repeat (n - 1) @(negedge clk);
    end
    repeat (12) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
